// File: rtl/id_stage_p.sv
// Instruction decode stage: IF/ID register, SRAM hold buffer, forwarding regfile read, decode.
// Define ID_BRANCH_EXT_EN to decode bne/bgez/bgtz/blez/bltz/bltzal/bgezal.
module id_stage_p #(
   parameter int unsigned N_FWD   = 3,
   parameter int unsigned STALL_W = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STALL_W-1:0]   stall,
   input  logic                 flush,
   input  logic                 if_valid,
   input  logic [31:0]          if_pc,
   input  logic [31:0]          inst_rdata,
   input  logic                 wb_we,
   input  logic [4:0]           wb_waddr,
   input  logic [31:0]          wb_wdata,
   input  logic [N_FWD-1:0]     fwd_we,
   input  logic [5*N_FWD-1:0]   fwd_waddr,
   input  logic [32*N_FWD-1:0]  fwd_wdata,
   input  logic                 ex_is_load,
   output logic                 stallreq,
   output logic                 id_valid,
   output logic [31:0]          id_pc,
   output logic [31:0]          id_inst,
   output logic [11:0]          alu_op,
   output logic [2:0]           sel_src1,
   output logic [3:0]           sel_src2,
   output logic                 rf_we,
   output logic [4:0]           rf_waddr,
   output logic [31:0]          rdata1,
   output logic [31:0]          rdata2,
   output logic                 br_e,
   output logic [31:0]          br_addr
);

   localparam logic [11:0] AluAdd = 12'h001, AluSub = 12'h002, AluAnd = 12'h004;
   localparam logic [11:0] AluOr  = 12'h008, AluXor = 12'h010, AluNor = 12'h020;
   localparam logic [11:0] AluSlt = 12'h040, AluSltu = 12'h080, AluSll = 12'h100;
   localparam logic [11:0] AluSrl = 12'h200, AluSra = 12'h400, AluLui = 12'h800;
   localparam logic [2:0]  Src1Rs = 3'b001, Src1Pc = 3'b010, Src1Sa = 3'b100;
   localparam logic [3:0]  Src2Rt = 4'b0001, Src2Sext = 4'b0010;
   localparam logic [3:0]  Src2Zext = 4'b0100, Src2Eight = 4'b1000;

   logic        id_valid_q, hold_valid_q;
   logic [31:0] id_pc_q, hold_q;
   logic [31:0] rf_q [32];

   // IF/ID register: a stall at IF/ID with ID/EX moving inserts a bubble
   always_ff @(posedge clk) begin
      if (rst || flush || (stall[1] && !stall[2])) begin
         id_valid_q <= 1'b0;
         id_pc_q    <= 32'd0;
      end else if (!stall[1]) begin
         id_valid_q <= if_valid;
         id_pc_q    <= if_pc;
      end
   end

   // SRAM data is only valid one cycle after the fetch, so keep a copy while ID/EX stalls
   always_ff @(posedge clk) begin
      if (rst || flush || !stall[2]) begin
         hold_valid_q <= 1'b0;
      end else if (id_valid_q && !hold_valid_q) begin
         hold_valid_q <= 1'b1;
         hold_q       <= inst_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (wb_we && wb_waddr != 5'd0) rf_q[wb_waddr] <= wb_wdata;
   end

   assign id_valid = id_valid_q;
   assign id_pc    = id_pc_q;
   assign id_inst  = !id_valid_q ? 32'd0 : (hold_valid_q ? hold_q : inst_rdata);

   // Lowest-index forwarding source wins, then the in-flight writeback, then the array
   function automatic logic [31:0] read_reg(input logic [4:0] addr);
      logic [31:0] val;
      val = (addr == 5'd0) ? 32'd0 : rf_q[addr];
      if (wb_we && wb_waddr == addr && addr != 5'd0) val = wb_wdata;
      for (int i = int'(N_FWD) - 1; i >= 0; i--) begin
         if (fwd_we[i] && fwd_waddr[5*i +: 5] == addr && addr != 5'd0) val = fwd_wdata[32*i +: 32];
      end
      return val;
   endfunction

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, ld_addr;
   logic [15:0] imm;
   logic [31:0] pc4, br_rel, jmp_abs, br_tgt;
   logic        rs_use, rt_use, r_alu, br_take;

   assign op      = id_inst[31:26];
   assign rs      = id_inst[25:21];
   assign rt      = id_inst[20:16];
   assign rd      = id_inst[15:11];
   assign funct   = id_inst[5:0];
   assign imm     = id_inst[15:0];
   assign pc4     = id_pc_q + 32'd4;
   assign br_rel  = pc4 + {{14{imm[15]}}, imm, 2'b00};
   assign jmp_abs = {pc4[31:28], id_inst[25:0], 2'b00};
   assign rdata1  = read_reg(rs);
   assign rdata2  = read_reg(rt);
   assign ld_addr = fwd_waddr[4:0];

   always_comb begin
      alu_op   = '0;
      sel_src1 = '0;
      sel_src2 = '0;
      rf_waddr = '0;
      rs_use   = 1'b0;
      rt_use   = 1'b0;
      r_alu    = 1'b0;
      br_take  = 1'b0;
      br_tgt   = '0;
      if (id_valid_q) begin
         case (op)
            6'h00: begin
               case (funct)
                  6'h21: begin r_alu = 1'b1; alu_op = AluAdd;  end
                  6'h23: begin r_alu = 1'b1; alu_op = AluSub;  end
                  6'h24: begin r_alu = 1'b1; alu_op = AluAnd;  end
                  6'h25: begin r_alu = 1'b1; alu_op = AluOr;   end
                  6'h26: begin r_alu = 1'b1; alu_op = AluXor;  end
                  6'h27: begin r_alu = 1'b1; alu_op = AluNor;  end
                  6'h2a: begin r_alu = 1'b1; alu_op = AluSlt;  end
                  6'h2b: begin r_alu = 1'b1; alu_op = AluSltu; end
                  6'h00, 6'h02, 6'h03: begin
                     alu_op   = (funct == 6'h00) ? AluSll : ((funct == 6'h02) ? AluSrl : AluSra);
                     sel_src1 = Src1Sa;
                     sel_src2 = Src2Rt;
                     rf_waddr = rd;
                     rt_use   = 1'b1;
                  end
                  6'h08: begin rs_use = 1'b1; br_take = 1'b1; br_tgt = rdata1; end
                  default: ;
               endcase
               if (r_alu) begin
                  sel_src1 = Src1Rs;
                  sel_src2 = Src2Rt;
                  rf_waddr = rd;
                  rs_use   = 1'b1;
                  rt_use   = 1'b1;
               end
            end
            6'h0d: begin
               alu_op = AluOr; sel_src1 = Src1Rs; sel_src2 = Src2Zext; rf_waddr = rt; rs_use = 1'b1;
            end
            6'h0f: begin alu_op = AluLui; sel_src2 = Src2Zext; rf_waddr = rt; end
            6'h09, 6'h23: begin
               alu_op = AluAdd; sel_src1 = Src1Rs; sel_src2 = Src2Sext; rf_waddr = rt; rs_use = 1'b1;
            end
            6'h2b: begin
               alu_op = AluAdd; sel_src1 = Src1Rs; sel_src2 = Src2Sext;
               rs_use = 1'b1; rt_use = 1'b1;
            end
            6'h04: begin
               rs_use = 1'b1; rt_use = 1'b1; br_take = (rdata1 == rdata2); br_tgt = br_rel;
            end
            6'h02: begin br_take = 1'b1; br_tgt = jmp_abs; end
            6'h03: begin
               alu_op = AluAdd; sel_src1 = Src1Pc; sel_src2 = Src2Eight; rf_waddr = 5'd31;
               br_take = 1'b1; br_tgt = jmp_abs;
            end
`ifdef ID_BRANCH_EXT_EN
            6'h05: begin
               rs_use = 1'b1; rt_use = 1'b1; br_take = (rdata1 != rdata2); br_tgt = br_rel;
            end
            6'h06: begin
               rs_use = 1'b1; br_take = rdata1[31] || (rdata1 == 32'd0); br_tgt = br_rel;
            end
            6'h07: begin
               rs_use = 1'b1; br_take = !rdata1[31] && (rdata1 != 32'd0); br_tgt = br_rel;
            end
            6'h01: begin
               // REGIMM: rt selects the condition; bit 4 marks the linking variants
               if (rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11) begin
                  rs_use  = 1'b1;
                  br_take = rt[0] ? !rdata1[31] : rdata1[31];
                  br_tgt  = br_rel;
                  if (rt[4]) begin
                     alu_op = AluAdd; sel_src1 = Src1Pc; sel_src2 = Src2Eight; rf_waddr = 5'd31;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign rf_we    = (rf_waddr != 5'd0);
   assign stallreq = id_valid_q && ex_is_load && (ld_addr != 5'd0) &&
                     ((rs_use && rs == ld_addr) || (rt_use && rt == ld_addr));
   assign br_e     = br_take && !stallreq;
   assign br_addr  = br_tgt;

   logic unused_stall;
   assign unused_stall = ^stall;

endmodule

// File: tb/tb_id_stage_p.sv
// Directed self-checking bench for id_stage_p (default N_FWD=3, STALL_W=6).
module tb_id_stage_p;
   logic         clk = 1'b0;
   logic         rst, flush, if_valid, wb_we, ex_is_load;
   logic [5:0]   stall;
   logic [31:0]  if_pc, inst_rdata, wb_wdata;
   logic [4:0]   wb_waddr;
   logic [2:0]   fwd_we;
   logic [14:0]  fwd_waddr;
   logic [95:0]  fwd_wdata;
   logic         stallreq, id_valid, rf_we, br_e;
   logic [31:0]  id_pc, id_inst, rdata1, rdata2, br_addr;
   logic [11:0]  alu_op;
   logic [2:0]   sel_src1;
   logic [3:0]   sel_src2;
   logic [4:0]   rf_waddr;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_stage_p dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
      .inst_rdata(inst_rdata), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .ex_is_load(ex_is_load),
      .stallreq(stallreq), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
      .alu_op(alu_op), .sel_src1(sel_src1), .sel_src2(sel_src2), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rdata1(rdata1), .rdata2(rdata2), .br_e(br_e), .br_addr(br_addr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [31:0] pc, input logic [31:0] inst);
      if_valid = 1'b1; if_pc = pc; stall = 6'd0; flush = 1'b0;
      tick();
      inst_rdata = inst;
      #1;
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
      tick();
      wb_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_valid = 1'b1; if_pc = 32'h123; inst_rdata = 32'h3C01_1234;
      tick();
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
      checks++; if (id_inst !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=0", id_inst); end
      checks++; if ({stallreq, rf_we, br_e} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {stallreq, rf_we, br_e}); end
      checks++; if ({alu_op, sel_src1, sel_src2, rf_waddr, br_addr} !== 56'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", {alu_op, sel_src1, sel_src2, rf_waddr, br_addr}); end
      rst = 1'b0;
   endtask

   task automatic test_wb_bypass();
      set_id(32'h100, 32'h00A0_1821); // addu r3,r5,r0
      wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h1234;
      #1;
      checks++; if (rdata1 !== 32'h1234) begin failures++; $display("FAIL wb_bypass got=%h exp=1234", rdata1); end
      checks++; if ({alu_op, sel_src1, sel_src2} !== {12'h001, 3'b001, 4'b0001}) begin failures++; $display("FAIL addu_ctrl got=%h exp=%h", {alu_op, sel_src1, sel_src2}, {12'h001, 3'b001, 4'b0001}); end
      checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd3}) begin failures++; $display("FAIL addu_wb got=%b/%0d exp=1/3", rf_we, rf_waddr); end
      tick();
      wb_we = 1'b0;
      #1;
      checks++; if (rdata1 !== 32'h1234) begin failures++; $display("FAIL rf_array got=%h exp=1234", rdata1); end
      wr_reg(5'd0, 32'hFFFF);
      set_id(32'h104, 32'h0000_1821); // addu r3,r0,r0
      wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF;
      #1;
      checks++; if (rdata1 !== 32'd0) begin failures++; $display("FAIL r0_zero got=%h exp=0", rdata1); end
      wb_we = 1'b0;
      set_id(32'h108, 32'h0022_0021); // addu r0,r1,r2
      checks++; if ({rf_we, rdata1, rdata2} !== {1'b0, 32'd5, 32'd7}) begin failures++; $display("FAIL rd0_nowrite got=%h exp=%h", {rf_we, rdata1, rdata2}, {1'b0, 32'd5, 32'd7}); end
   endtask

   task automatic test_fwd();
      set_id(32'h10C, 32'h0100_1821); // addu r3,r8,r0
      fwd_we = 3'b101; fwd_waddr = {5'd8, 5'd0, 5'd8};
      fwd_wdata = {32'hBBBB, 32'h0, 32'hAAAA};
      #1;
      checks++; if (rdata1 !== 32'hAAAA) begin failures++; $display("FAIL fwd_prio got=%h exp=aaaa", rdata1); end
      fwd_we = 3'b100; wb_we = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'hCCCC;
      #1;
      checks++; if (rdata1 !== 32'hBBBB) begin failures++; $display("FAIL fwd_over_wb got=%h exp=bbbb", rdata1); end
      fwd_we = 3'b000;
      #1;
      checks++; if (rdata1 !== 32'hCCCC) begin failures++; $display("FAIL wb_no_fwd got=%h exp=cccc", rdata1); end
      wb_we = 1'b0; fwd_waddr = '0; fwd_wdata = '0;
   endtask

   task automatic test_load_use();
      set_id(32'h110, 32'h0122_0821); // addu r1,r9,r2
      ex_is_load = 1'b1; fwd_waddr = {10'd0, 5'd9};
      #1;
      checks++; if ({stallreq, br_e} !== 2'b10) begin failures++; $display("FAIL load_use_rs got=%b exp=10", {stallreq, br_e}); end
      ex_is_load = 1'b0;
      #1;
      checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL load_use_clear got=%b exp=0", stallreq); end
      ex_is_load = 1'b1; fwd_waddr = {10'd0, 5'd2};
      #1;
      checks++; if (stallreq !== 1'b1) begin failures++; $display("FAIL load_use_rt got=%b exp=1", stallreq); end
      fwd_waddr = {10'd0, 5'd1};
      set_id(32'h114, 32'h3C01_1234); // lui r1 reads nothing
      checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL lui_nostall got=%b exp=0", stallreq); end
      set_id(32'h118, 32'h1021_0004); // beq r1,r1 behind load to r1
      checks++; if ({stallreq, br_e} !== 2'b10) begin failures++; $display("FAIL br_suppress got=%b exp=10", {stallreq, br_e}); end
      ex_is_load = 1'b0; fwd_waddr = '0;
   endtask

   task automatic test_hold();
      set_id(32'h200, 32'h3C01_1234);
      stall = 6'b000110;
      tick();
      for (int i = 0; i < 3; i++) begin
         inst_rdata = 32'hDEAD_0000 + i;
         #1;
         checks++; if (id_inst !== 32'h3C01_1234) begin failures++; $display("FAIL hold_inst%0d got=%h exp=3c011234", i, id_inst); end
         tick();
      end
      checks++; if ({alu_op, rf_waddr} !== {12'h800, 5'd1}) begin failures++; $display("FAIL lui_ctrl got=%h exp=%h", {alu_op, rf_waddr}, {12'h800, 5'd1}); end
      stall = 6'd0;
      tick();
      inst_rdata = 32'h00A0_1821;
      #1;
      checks++; if (id_inst !== 32'h00A0_1821) begin failures++; $display("FAIL hold_release got=%h exp=00a01821", id_inst); end
   endtask

   task automatic test_rst_mid_stall();
      set_id(32'h300, 32'h3C01_1234);
      stall = 6'b000110;
      tick();
      rst = 1'b1;
      tick();
      checks++; if ({id_valid, id_inst} !== 33'd0) begin failures++; $display("FAIL rst_stall got=%h exp=0", {id_valid, id_inst}); end
      rst = 1'b0; stall = 6'b000100; if_pc = 32'h304; inst_rdata = 32'h3C02_5678;
      tick();
      checks++; if ({id_pc, id_inst} !== {32'h304, 32'h3C02_5678}) begin failures++; $display("FAIL rst_hold_drop got=%h exp=%h", {id_pc, id_inst}, {32'h304, 32'h3C02_5678}); end
      stall = 6'd0;
   endtask

   task automatic test_bubble_hold();
      set_id(32'h400, 32'h3C01_1234);
      stall = 6'b000010;
      tick();
      checks++; if ({id_valid, id_pc} !== 33'd0) begin failures++; $display("FAIL bubble got=%h exp=0", {id_valid, id_pc}); end
      set_id(32'h404, 32'h3C01_1234);
      stall = 6'b000110; if_pc = 32'h999;
      tick();
      checks++; if ({id_valid, id_pc} !== {1'b1, 32'h404}) begin failures++; $display("FAIL ifid_hold got=%h exp=%h", {id_valid, id_pc}, {1'b1, 32'h404}); end
      stall = 6'd0;
   endtask

   task automatic test_branch();
      set_id(32'hBFC0_0000, 32'h1021_0004); // beq r1,r1,+4
      checks++; if ({br_e, br_addr} !== {1'b1, 32'hBFC0_0014}) begin failures++; $display("FAIL beq_taken got=%h exp=%h", {br_e, br_addr}, {1'b1, 32'hBFC0_0014}); end
      flush = 1'b1;
      tick();
      checks++; if ({id_valid, br_e} !== 2'b00) begin failures++; $display("FAIL flush got=%b exp=00", {id_valid, br_e}); end
      flush = 1'b0;
      set_id(32'hBFC0_0000, 32'h1022_0004); // beq r1,r2 not taken
      checks++; if (br_e !== 1'b0) begin failures++; $display("FAIL beq_nt got=%b exp=0", br_e); end
      set_id(32'hFFFF_FFFC, 32'h1000_FFFF); // beq r0,r0,-1 across wrap
      checks++; if ({br_e, br_addr} !== {1'b1, 32'hFFFF_FFFC}) begin failures++; $display("FAIL beq_wrap got=%h exp=%h", {br_e, br_addr}, {1'b1, 32'hFFFF_FFFC}); end
      set_id(32'h1000_0000, 32'h0812_3456); // j
      checks++; if ({br_e, rf_we, br_addr} !== {2'b10, 32'h1048_D158}) begin failures++; $display("FAIL j got=%h exp=%h", {br_e, rf_we, br_addr}, {2'b10, 32'h1048_D158}); end
      set_id(32'h1000_0000, 32'h0C12_3456); // jal
      checks++; if ({rf_we, rf_waddr, alu_op, sel_src1, sel_src2} !== {1'b1, 5'd31, 12'h001, 3'b010, 4'b1000}) begin failures++; $display("FAIL jal_link got=%h exp=%h", {rf_we, rf_waddr, alu_op, sel_src1, sel_src2}, {1'b1, 5'd31, 12'h001, 3'b010, 4'b1000}); end
      set_id(32'h500, 32'h03E0_0008); // jr r31
      checks++; if ({br_e, br_addr} !== {1'b1, 32'h0040_0100}) begin failures++; $display("FAIL jr got=%h exp=%h", {br_e, br_addr}, {1'b1, 32'h0040_0100}); end
   endtask

   task automatic test_decode();
      set_id(32'h600, 32'h0001_10C0); // sll r2,r1,3
      checks++; if ({alu_op, sel_src1, sel_src2, rf_waddr} !== {12'h100, 3'b100, 4'b0001, 5'd2}) begin failures++; $display("FAIL sll got=%h exp=%h", {alu_op, sel_src1, sel_src2, rf_waddr}, {12'h100, 3'b100, 4'b0001, 5'd2}); end
      set_id(32'h604, 32'h3424_00FF); // ori r4,r1,0xff
      checks++; if ({alu_op, sel_src1, sel_src2, rf_waddr} !== {12'h008, 3'b001, 4'b0100, 5'd4}) begin failures++; $display("FAIL ori got=%h exp=%h", {alu_op, sel_src1, sel_src2, rf_waddr}, {12'h008, 3'b001, 4'b0100, 5'd4}); end
      set_id(32'h608, 32'hFC00_0000); // unknown opcode
      checks++; if ({rf_we, alu_op, br_e} !== 14'd0) begin failures++; $display("FAIL nop got=%h exp=0", {rf_we, alu_op, br_e}); end
      set_id(32'h60C, 32'h1422_0000); // bne r1,r2
`ifdef ID_BRANCH_EXT_EN
      checks++; if ({br_e, br_addr} !== {1'b1, 32'h610}) begin failures++; $display("FAIL bne_ext got=%h exp=%h", {br_e, br_addr}, {1'b1, 32'h610}); end
`else
      checks++; if ({br_e, rf_we, alu_op} !== 14'd0) begin failures++; $display("FAIL bne_nop got=%h exp=0", {br_e, rf_we, alu_op}); end
`endif
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall = 6'd0; if_valid = 1'b0; if_pc = '0; inst_rdata = '0;
      wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0; fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
      ex_is_load = 1'b0;
      test_reset();
      wr_reg(5'd1, 32'd5);
      wr_reg(5'd2, 32'd7);
      wr_reg(5'd31, 32'h0040_0100);
      test_wb_bypass();
      test_fwd();
      test_load_use();
      test_hold();
      test_rst_mid_stall();
      test_bubble_hold();
      test_branch();
      test_decode();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
